// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared encodings for the cache-side sram-like ports
package cache_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_ADDR = 2'b01,
    ARB_DATA = 2'b10
  } arb_state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/sram_like_cache_arbiter_if.sv
// rtl/sram_like_cache_arbiter_if.sv - one sram-like request/response port
interface sram_like_cache_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  // master issues the request, slave answers with addr_ok/data_ok/rdata
  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/arb_streak_ctr.sv
// rtl/arb_streak_ctr.sv - consecutive D-grant counter that forces an I grant
module arb_streak_ctr #(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic grant,
  input  logic grant_d,
  input  logic i_req,
  output logic force_i
);

  localparam logic [STREAK_W-1:0] MAX_V = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic                at_max;

  assign at_max  = (streak_q == MAX_V);
  assign force_i = i_req & at_max;

  // count D grants that bypassed a waiting I request; any other grant clears the streak
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else if (grant) begin
      if (grant_d && i_req) begin
        if (!at_max) streak_q <= streak_q + STREAK_W'(1);
      end else begin
        streak_q <= '0;
      end
    end
  end

endmodule

// File: rtl/sram_like_cache_arbiter.sv
// rtl/sram_like_cache_arbiter.sv - shares one sram-like bridge port between I- and D-cache
module sram_like_cache_arbiter
  import cache_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 3
) (
  input logic                       clk,
  input logic                       rst,
  sram_like_cache_arbiter_if.slave  i_bus,
  sram_like_cache_arbiter_if.slave  d_bus,
  sram_like_cache_arbiter_if.master mem_bus
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       boot_q;
  logic       any_req;
  logic       force_i;
  logic       pick;
  logic       sel;
  logic       grant;
  logic       mem_req;
  logic       addr_ok_eff;
  logic       data_ok_eff;

  assign any_req = i_bus.req | d_bus.req;

  // bridge handshakes are ignored in reset and in the first cycle after it,
  // so a stale response from a killed transaction can never leak through
  assign addr_ok_eff = mem_bus.addr_ok & ~rst & ~boot_q;
  assign data_ok_eff = mem_bus.data_ok & ~rst & ~boot_q;

  assign pick = (d_bus.req & ~force_i) ? OWNER_D : (i_bus.req ? OWNER_I : OWNER_D);
  assign sel  = (state_q == ARB_IDLE) ? pick : owner_q;

  assign grant   = ~rst & (state_q == ARB_IDLE) & any_req;
  assign mem_req = ~rst & (((state_q == ARB_IDLE) & any_req) | (state_q == ARB_ADDR));

  arb_streak_ctr #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .STREAK_W     (STREAK_W)
  ) u_streak (
    .clk     (clk),
    .rst     (rst),
    .grant   (grant),
    .grant_d (pick == OWNER_D),
    .i_req   (i_bus.req),
    .force_i (force_i)
  );

  // state, owner and post-reset marker registers
  always_ff @(posedge clk) begin
    boot_q <= rst;
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // next state: lock the owner on grant, then follow the bridge handshakes
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          owner_d = pick;
          state_d = addr_ok_eff ? ARB_DATA : ARB_ADDR;
        end
      end
      ARB_ADDR: if (addr_ok_eff) state_d = ARB_DATA;
      ARB_DATA: if (data_ok_eff) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // outputs: request mux toward the bridge and handshake routing back to the owner
  always_comb begin
    mem_bus.req = mem_req;
    if (sel == OWNER_D) begin
      mem_bus.wr    = d_bus.wr;
      mem_bus.size  = d_bus.size;
      mem_bus.addr  = d_bus.addr;
      mem_bus.wdata = d_bus.wdata;
    end else begin
      mem_bus.wr    = i_bus.wr;
      mem_bus.size  = i_bus.size;
      mem_bus.addr  = i_bus.addr;
      mem_bus.wdata = i_bus.wdata;
    end
    i_bus.addr_ok = addr_ok_eff & mem_req & (sel == OWNER_I);
    d_bus.addr_ok = addr_ok_eff & mem_req & (sel == OWNER_D);
    i_bus.data_ok = data_ok_eff & (state_q == ARB_DATA) & (owner_q == OWNER_I);
    d_bus.data_ok = data_ok_eff & (state_q == ARB_DATA) & (owner_q == OWNER_D);
    i_bus.rdata   = mem_bus.rdata;
    d_bus.rdata   = mem_bus.rdata;
  end

endmodule

// File: tb/tb_sram_like_cache_arbiter.sv
// tb/tb_sram_like_cache_arbiter.sv - scoreboard bench for the I/D cache arbiter
module tb_sram_like_cache_arbiter;
  import cache_pkg::*;

  typedef struct packed {
    logic        side;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst;
  logic br_rst;
  int   n_chk;
  int   n_err;
  exp_t sb[$];

  int          addr_lat;
  int          data_lat;
  int          wcnt;
  int          dcnt;
  logic        bbusy;
  logic [31:0] baddr;

  sram_like_cache_arbiter_if ibus ();
  sram_like_cache_arbiter_if dbus ();
  sram_like_cache_arbiter_if mbus ();

  sram_like_cache_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .i_bus   (ibus),
    .d_bus   (dbus),
    .mem_bus (mbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h3C1D_0000 : (a ^ 32'hA5A5_0F0F);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // bridge model: addr_ok after addr_lat waiting cycles, data_ok data_lat cycles after accept
  assign mbus.addr_ok = mbus.req && !bbusy && (wcnt >= addr_lat);
  assign mbus.data_ok = bbusy && (dcnt == data_lat);
  assign mbus.rdata   = bbusy ? mem_model(baddr) : 32'h0;

  always @(posedge clk) begin
    if (br_rst) begin
      bbusy <= 1'b0;
      wcnt  <= 0;
      dcnt  <= 0;
      baddr <= 32'h0;
    end else if (bbusy) begin
      if (dcnt == data_lat) bbusy <= 1'b0;
      else dcnt <= dcnt + 1;
    end else if (mbus.req) begin
      if (mbus.addr_ok) begin
        bbusy <= 1'b1;
        dcnt  <= 1;
        baddr <= mbus.addr;
        wcnt  <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // completion monitor: every data_ok must match the oldest expectation
  always @(negedge clk) begin
    if (ibus.data_ok === 1'b1 || dbus.data_ok === 1'b1) begin
      check("sb_both_data_ok", 32'(ibus.data_ok & dbus.data_ok), 0);
      if (sb.size() == 0) begin
        check("sb_unexpected_data_ok", 32'({ibus.data_ok, dbus.data_ok}), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_side", 32'(dbus.data_ok), 32'(e.side));
        check("sb_rdata", dbus.data_ok ? dbus.rdata : ibus.rdata, e.rdata);
      end
    end
  end

  task automatic drain;
    int c;
    c = 0;
    while (sb.size() != 0 && c < 40) begin
      tick();
      c++;
    end
    check("drain", sb.size(), 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] ord;
    logic       side;
    logic       found;
    int         c;

    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    br_rst = 1'b1;
    addr_lat = 0;
    data_lat = 1;
    ibus.req = 1'b0; ibus.wr = 1'b0; ibus.size = SZ_WORD; ibus.addr = 32'h0; ibus.wdata = 32'h0;
    dbus.req = 1'b0; dbus.wr = 1'b0; dbus.size = SZ_WORD; dbus.addr = 32'h0; dbus.wdata = 32'h0;

    // reset and first post-reset cycle
    tick(); tick();
    @(negedge clk);
    check("rst_i_addr_ok", 32'(ibus.addr_ok), 0);
    check("rst_d_data_ok", 32'(dbus.data_ok), 0);
    tick();
    rst = 1'b0; br_rst = 1'b0;
    @(negedge clk);
    check("post_rst_mem_req", 32'(mbus.req), 0);
    check("post_rst_d_addr_ok", 32'(dbus.addr_ok), 0);
    tick(); tick();

    // lone I read
    addr_lat = 0; data_lat = 3;
    ibus.req = 1'b1; ibus.addr = 32'hBFC0_0000; ibus.size = SZ_WORD;
    sb.push_back('{side: OWNER_I, rdata: 32'h3C1D_0000});
    @(negedge clk);
    check("t1_i_addr_ok", 32'(ibus.addr_ok), 1);
    check("t1_d_addr_ok", 32'(dbus.addr_ok), 0);
    check("t1_mem_addr", mbus.addr, 32'hBFC0_0000);
    tick();
    ibus.req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("t1_i_data_ok", 32'(ibus.data_ok), (k == 3) ? 1 : 0);
      check("t1_d_addr_ok_late", 32'(dbus.addr_ok), 0);
      if (k == 3) check("t1_i_rdata", ibus.rdata, 32'h3C1D_0000);
      tick();
    end
    drain();

    // simultaneous requests: D first, I right after the turnaround
    data_lat = 2;
    ibus.req = 1'b1; ibus.addr = 32'h0000_1000;
    dbus.req = 1'b1; dbus.addr = 32'h0000_2000;
    sb.push_back('{side: OWNER_D, rdata: mem_model(32'h0000_2000)});
    sb.push_back('{side: OWNER_I, rdata: mem_model(32'h0000_1000)});
    @(negedge clk);
    check("t2_mem_addr_d", mbus.addr, 32'h0000_2000);
    check("t2_d_addr_ok", 32'(dbus.addr_ok), 1);
    check("t2_i_addr_ok", 32'(ibus.addr_ok), 0);
    tick();
    dbus.req = 1'b0;
    @(negedge clk);
    check("t2_mem_req_data", 32'(mbus.req), 0);
    tick();
    @(negedge clk);
    check("t2_d_data_ok", 32'(dbus.data_ok), 1);
    check("t2_i_addr_ok_turn", 32'(ibus.addr_ok), 0);
    tick();
    @(negedge clk);
    check("t2_i_addr_ok_next", 32'(ibus.addr_ok), 1);
    check("t2_mem_addr_i", mbus.addr, 32'h0000_1000);
    tick();
    ibus.req = 1'b0;
    drain();

    // slow addr_ok: owner stays D while I arrives
    addr_lat = 5; data_lat = 1;
    dbus.req = 1'b1; dbus.addr = 32'h0000_3000;
    sb.push_back('{side: OWNER_D, rdata: mem_model(32'h0000_3000)});
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("t3_mem_addr_stable", mbus.addr, 32'h0000_3000);
      check("t3_d_addr_ok", 32'(dbus.addr_ok), (k == 5) ? 1 : 0);
      check("t3_i_addr_ok", 32'(ibus.addr_ok), 0);
      tick();
      if (k == 0) begin
        ibus.req = 1'b1; ibus.addr = 32'h0000_4000;
        sb.push_back('{side: OWNER_I, rdata: mem_model(32'h0000_4000)});
      end
      if (k == 5) begin
        dbus.req = 1'b0;
        addr_lat = 0;
      end
    end
    @(negedge clk);
    check("t3_d_data_ok", 32'(dbus.data_ok), 1);
    tick();
    @(negedge clk);
    check("t3_i_addr_ok_after", 32'(ibus.addr_ok), 1);
    check("t3_mem_addr_i", mbus.addr, 32'h0000_4000);
    tick();
    ibus.req = 1'b0;
    drain();

    // streak: both held high, expected D,D,D,D,I,D,D,D,D,I
    addr_lat = 0; data_lat = 1;
    ord = 10'b01111_01111;
    for (int g = 0; g < 10; g++)
      sb.push_back('{side: ord[g], rdata: mem_model(ord[g] ? 32'h0000_5000 : 32'h0000_6000)});
    dbus.req = 1'b1; dbus.addr = 32'h0000_5000;
    ibus.req = 1'b1; ibus.addr = 32'h0000_6000;
    for (int g = 0; g < 10; g++) begin
      c = 0;
      found = 1'b0;
      side = 1'b0;
      while (!found && c < 12) begin
        @(negedge clk);
        if (ibus.addr_ok === 1'b1 || dbus.addr_ok === 1'b1) begin
          found = 1'b1;
          side = dbus.addr_ok;
        end else begin
          tick();
          c++;
        end
      end
      if (!found) check("t4_grant_timeout", 0, 1);
      else check("t4_grant_order", 32'(side), 32'(ord[g]));
      tick();
      if (g == 9) begin
        dbus.req = 1'b0;
        ibus.req = 1'b0;
      end
    end
    drain();

    // D byte write passes straight through
    data_lat = 2;
    dbus.req = 1'b1; dbus.wr = 1'b1; dbus.size = SZ_BYTE;
    dbus.addr = 32'h8000_1003; dbus.wdata = 32'h0000_00AB;
    sb.push_back('{side: OWNER_D, rdata: mem_model(32'h8000_1003)});
    @(negedge clk);
    check("t5_mem_wr", 32'(mbus.wr), 1);
    check("t5_mem_size", 32'(mbus.size), 32'(SZ_BYTE));
    check("t5_mem_addr", mbus.addr, 32'h8000_1003);
    check("t5_mem_wdata", mbus.wdata, 32'h0000_00AB);
    check("t5_d_addr_ok", 32'(dbus.addr_ok), 1);
    tick();
    dbus.req = 1'b0; dbus.wr = 1'b0; dbus.size = SZ_WORD;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("t5_d_data_ok", 32'(dbus.data_ok), 1);
    drain();

    // reset while in DATA; late bridge data_ok must be dropped
    addr_lat = 0; data_lat = 6;
    dbus.req = 1'b1; dbus.addr = 32'h0000_7000;
    @(negedge clk);
    check("t6_d_addr_ok", 32'(dbus.addr_ok), 1);
    tick();
    dbus.req = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("t6_rst_d_data_ok", 32'(dbus.data_ok), 0);
    check("t6_rst_d_addr_ok", 32'(dbus.addr_ok), 0);
    tick();
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_rst_i_data_ok", 32'(ibus.data_ok), 0);
    check("t6_post_rst_mem_req", 32'(mbus.req), 0);
    tick();
    tick();
    @(negedge clk);
    check("t6_late_data_ok_dropped", 32'(dbus.data_ok), 0);
    tick();
    ibus.req = 1'b1; ibus.addr = 32'h0000_8000;
    sb.push_back('{side: OWNER_I, rdata: mem_model(32'h0000_8000)});
    @(negedge clk);
    check("t6_i_addr_ok_after_rst", 32'(ibus.addr_ok), 1);
    tick();
    ibus.req = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
